// File: rtl/dircc_types_pkg.sv
// Shared types and width helpers for the Avalon-ST packet FIFO.
// Framing state and the empty-field width rule live here so every file agrees on them.
package dircc_types_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      IN_PACKET = 1'b1
   } frame_state_t;

   // A one-symbol beat still carries a 1-bit empty field rather than a zero-width one.
   function automatic int empty_width(input int symbols_per_beat);
      return (symbols_per_beat > 1) ? $clog2(symbols_per_beat) : 1;
   endfunction

endpackage

// File: rtl/dircc_st_packet_fifo_if.sv
// Avalon-ST stream bundle: data, empty, framing, valid/ready with readyLatency 0.
// The master drives the beat and valid; the slave drives ready.
interface dircc_st_packet_fifo_if #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 4
);
   import dircc_types_pkg::*;

   localparam int DATA_WIDTH  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
   localparam int EMPTY_WIDTH = empty_width(SYMBOLS_PER_BEAT);

   logic [DATA_WIDTH-1:0]  data;
   logic [EMPTY_WIDTH-1:0] empty;
   logic                   startofpacket;
   logic                   endofpacket;
   logic                   valid;
   logic                   ready;

   modport master (
      output data, empty, startofpacket, endofpacket, valid,
      input  ready
   );

   modport slave (
      input  data, empty, startofpacket, endofpacket, valid,
      output ready
   );

endinterface

// File: rtl/dircc_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: registered write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the pointers and counts.
module dircc_fifo_ram #(
   parameter  int WIDTH      = 36,
   parameter  int DEPTH      = 8,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dircc_st_packet_fifo.sv
// Store-and-forward Avalon-ST packet FIFO between the network and a PE packet receiver.
// Oversize packets that fill the FIFO are forwarded cut-through so the link never deadlocks.
module dircc_st_packet_fifo
   import dircc_types_pkg::*;
#(
   parameter  int BITS_PER_SYMBOL  = 8,
   parameter  int SYMBOLS_PER_BEAT = 4,
   parameter  int INPUT_FIFO_DEPTH = 8,
   localparam int COUNT_WIDTH      = $clog2(INPUT_FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   dircc_st_packet_fifo_if.slave  in_st,
   dircc_st_packet_fifo_if.master out_st,
   output logic [COUNT_WIDTH-1:0] beat_count,
   output logic [COUNT_WIDTH-1:0] packet_count,
   output logic                   protocol_error
);

   localparam int DATA_WIDTH  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
   localparam int EMPTY_WIDTH = empty_width(SYMBOLS_PER_BEAT);
   localparam int ENTRY_WIDTH = DATA_WIDTH + EMPTY_WIDTH + 2;
   localparam int ADDR_WIDTH  = $clog2(INPUT_FIFO_DEPTH);
   localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(INPUT_FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0]  wr_ptr;
   logic [ADDR_WIDTH-1:0]  rd_ptr;
   logic [COUNT_WIDTH-1:0] beat_cnt;
   logic [COUNT_WIDTH-1:0] pkt_cnt;
   frame_state_t           state;
   frame_state_t           state_nxt;
   logic                   err_nxt;
   logic                   err_p1;
   logic                   in_ready_c;
   logic                   out_valid_c;
   logic                   accept;
   logic                   stray;
   logic                   wr_en;
   logic                   rd_en;
   logic                   wr_pkt;
   logic                   rd_pkt;
   logic [ENTRY_WIDTH-1:0] wr_entry;
   logic [ENTRY_WIDTH-1:0] rd_entry;

   // Ready depends only on stored occupancy, so a same-cycle read cannot open the sink.
   assign in_ready_c  = (beat_cnt < DEPTH_C);
   assign out_valid_c = (pkt_cnt != '0) || (beat_cnt == DEPTH_C);

   assign accept = in_st.valid && in_ready_c;
   assign stray  = accept && (state == IDLE) && !in_st.startofpacket;
   assign wr_en  = accept && !stray;
   assign rd_en  = out_valid_c && out_st.ready;
   assign wr_pkt = wr_en && in_st.endofpacket;
   assign rd_pkt = rd_en && rd_entry[0];

   assign wr_entry = {in_st.data, in_st.empty, in_st.startofpacket, in_st.endofpacket};

   dircc_fifo_ram #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (INPUT_FIFO_DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   assign in_st.ready  = in_ready_c;
   assign out_st.valid = out_valid_c;
   assign {out_st.data, out_st.empty, out_st.startofpacket, out_st.endofpacket} = rd_entry;

   assign beat_count     = beat_cnt;
   assign packet_count   = pkt_cnt;
   assign protocol_error = err_p1;

   // Framing decisions are made on every accepted beat, including discarded strays.
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      if (accept) begin
         case (state)
            IDLE: begin
               if (in_st.startofpacket) begin
                  state_nxt = in_st.endofpacket ? IDLE : IN_PACKET;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            IN_PACKET: begin
               if (in_st.startofpacket) begin
                  err_nxt = 1'b1;
               end
               if (in_st.endofpacket) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Stage p1: framing state and the registered error pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         err_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         err_p1 <= err_nxt;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
         pkt_cnt  <= '0;
      end else begin
         case ({wr_en, rd_en})
            2'b10:   beat_cnt <= beat_cnt + COUNT_WIDTH'(1);
            2'b01:   beat_cnt <= beat_cnt - COUNT_WIDTH'(1);
            default: beat_cnt <= beat_cnt;
         endcase
         case ({wr_pkt, rd_pkt})
            2'b10:   pkt_cnt <= pkt_cnt + COUNT_WIDTH'(1);
            2'b01:   pkt_cnt <= pkt_cnt - COUNT_WIDTH'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

endmodule

// File: doc/dircc_st_packet_fifo.md
DIRCC_ST_PACKET_FIFO -- requirements
Module: dircc_st_packet_fifo

Interface
REQ-001 Parameter BITS_PER_SYMBOL, default 8, bits per Avalon-ST symbol.
REQ-002 Parameter SYMBOLS_PER_BEAT, default 4, symbols per beat; DATA_WIDTH = product, EMPTY_WIDTH = clog2(SYMBOLS_PER_BEAT).
REQ-003 Parameter INPUT_FIFO_DEPTH, default 8, beat capacity; power of two, minimum 2; COUNT_WIDTH = clog2(INPUT_FIFO_DEPTH+1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data / in_empty / in_startofpacket / in_endofpacket / in_valid  input  DATA_WIDTH / EMPTY_WIDTH / 1 / 1 / 1  upstream (network) Avalon-ST sink.
REQ-007 in_ready  output  1  sink ready; readyLatency 0.
REQ-008 out_data / out_empty / out_startofpacket / out_endofpacket / out_valid  output  DATA_WIDTH / EMPTY_WIDTH / 1 / 1 / 1  source feeding the processing-element packet receiver.
REQ-009 out_ready  input  1  downstream ready; readyLatency 0.
REQ-010 beat_count  output  COUNT_WIDTH  beats currently stored.
REQ-011 packet_count  output  COUNT_WIDTH  complete packets (eop stored) currently stored.
REQ-012 protocol_error  output  1  one-cycle pulse on a malformed input beat.

Function
REQ-013 Write occurs when in_valid && in_ready; read occurs when out_valid && out_ready.
REQ-014 Each stored entry holds {data, empty, sop, eop}, unmodified.
REQ-015 in_ready SHALL be 1 whenever beat_count < INPUT_FIFO_DEPTH, combinationally; simultaneous read does not raise in_ready in the same cycle.
REQ-016 Store-and-forward: out_valid = (packet_count > 0) || (beat_count == INPUT_FIFO_DEPTH); the full-FIFO term forwards oversize packets cut-through, preventing deadlock.
REQ-017 out_* SHALL show the entry at the read pointer (first-word fall-through); data stable while out_valid && !out_ready.
REQ-018 Latency: a 1-beat packet written in cycle N is presented with out_valid in cycle N+1.
REQ-019 Read and write pointers SHALL wrap modulo INPUT_FIFO_DEPTH.
REQ-020 beat_count: +1 on write only, -1 on read only, unchanged on both.
REQ-021 packet_count: +1 on writing an eop beat, -1 on reading an eop beat, unchanged on both.
REQ-022 Framing state machine, states IDLE and IN_PACKET: IDLE -> IN_PACKET on written sop without eop; IN_PACKET -> IDLE on written eop; sop+eop beat in IDLE stays IDLE.
REQ-023 Beat without sop offered in IDLE SHALL be accepted (in_ready honoured), discarded (not stored, no count change), with protocol_error pulsed the next cycle.
REQ-024 Beat with sop written in IN_PACKET SHALL be stored as-is, restart framing as a new packet, and pulse protocol_error the next cycle.
REQ-025 No stored beat is ever dropped or overwritten; with in_ready low, input beats are held off, not lost.

Reset
REQ-026 On reset_n low: pointers, beat_count, packet_count = 0; state IDLE; out_valid = 0; protocol_error = 0; in_ready = 1 after release.
REQ-027 Reset asserted mid-packet SHALL discard all stored beats; storage array contents need no reset.
REQ-028 The first write is accepted on the first rising clk edge after reset_n deasserts.

Structure
REQ-029 The framing-state enum belongs in dircc_types_pkg; widths derive locally from parameters.
REQ-030 One sub-module is natural: dircc_fifo_ram (simple dual-port, async read, registered write); the pointer, count and framing logic stays in the top.

Verification
REQ-031 Depth 8, one 3-beat packet, out_ready=1 -> out_valid rises only after eop is written, beats emerge in order, packet_count 1 -> 0.
REQ-032 Depth 8, 10-beat packet, out_ready=0 -> in_ready=0 at beat_count 8, out_valid=1 (cut-through); releasing out_ready drains all 10 beats intact.
REQ-033 Simultaneous write of a 1-beat packet and read of an eop beat with packet_count=1 -> beat_count and packet_count unchanged, pointers advance by 1.
REQ-034 Stray beat (sop=0) in IDLE -> not stored, beat_count stays 0, protocol_error pulses once.
REQ-035 Reset asserted after 2 beats of a 4-beat packet -> counts 0, out_valid 0; a subsequent clean packet passes correctly.
REQ-036 Random back-pressure on both sides, 1000 packets of 1-12 beats -> scoreboard shows zero loss and zero reorder.
